// File: rtl/banco_pkg.sv
// banco_pkg: shared state type and power-on value helper for the multiport register file.
package banco_pkg;

    typedef enum logic {INIT, OPER} estado_t;

    function automatic logic [31:0] val_init(input logic [31:0] idx, input logic [31:0] n_init);
        return (idx < n_init) ? idx + 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/banco_seq_init.sv
// banco_seq_init: INIT/OPER sequencer that walks every entry once after reset or a clear request,
// and flags writes that arrive while it is busy.
module banco_seq_init
    import banco_pkg::*;
#(
    parameter int ANCHO  = 32,
    parameter int PROF   = 32,
    parameter int N_INIT = 8,
    parameter int DIR_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_limpiar,
    input  logic             i_we,
    output logic             o_ocupado,
    output logic             o_rechazo,
    output logic             o_oper,
    output logic             o_init_we,
    output logic [DIR_W-1:0] o_init_dir,
    output logic [ANCHO-1:0] o_init_dato
);

    localparam logic [DIR_W-1:0] ULTIMO = DIR_W'(PROF - 1);

    estado_t          r_estado;
    logic [DIR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= INIT;
            r_cnt     <= '0;
            o_ocupado <= 1'b1;
            o_rechazo <= 1'b0;
        end else begin
            o_rechazo <= i_we && o_ocupado;
            if (r_estado == INIT) begin
                r_cnt <= (r_cnt == ULTIMO) ? '0 : r_cnt + DIR_W'(1);
                if (r_cnt == ULTIMO) begin
                    r_estado  <= OPER;
                    o_ocupado <= 1'b0;
                end
            end else if (i_limpiar) begin
                r_estado  <= INIT;
                r_cnt     <= '0;
                o_ocupado <= 1'b1;
            end
        end
    end

    assign o_oper      = (r_estado == OPER);
    assign o_init_we   = (r_estado == INIT);
    assign o_init_dir  = r_cnt;
    assign o_init_dato = ANCHO'(val_init(32'(r_cnt), 32'(N_INIT)));

endmodule

// File: rtl/banco_reg_multipuerto.sv
// banco_reg_multipuerto: parametrised register file with N_LECT registered read ports and a hardware init sequencer.
// Define BANCO_BYPASS_EN for write-through on same-address write/read; default is read-before-write.
module banco_reg_multipuerto #(
    parameter int   ANCHO  = 32,
    parameter int   PROF   = 32,
    parameter int   N_LECT = 2,
    parameter int   N_INIT = 8,
    localparam int  DIR_W  = $clog2(PROF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    limpiar,
    input  logic                    we,
    input  logic [DIR_W-1:0]        dir_esc,
    input  logic [ANCHO-1:0]        dato,
    input  logic [N_LECT*DIR_W-1:0] dir_lect,
    output logic [N_LECT*ANCHO-1:0] q,
    output logic                    ocupado,
    output logic                    rechazo
);

    localparam logic [DIR_W:0] LIM = (DIR_W + 1)'(PROF);

    logic [ANCHO-1:0] r_mem [PROF];
    logic             w_oper;
    logic             w_init_we;
    logic [DIR_W-1:0] w_init_dir;
    logic [ANCHO-1:0] w_init_dato;
    logic             w_esc;

    banco_seq_init #(
        .ANCHO (ANCHO),
        .PROF  (PROF),
        .N_INIT(N_INIT),
        .DIR_W (DIR_W)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_limpiar  (limpiar),
        .i_we       (we),
        .o_ocupado  (ocupado),
        .o_rechazo  (rechazo),
        .o_oper     (w_oper),
        .o_init_we  (w_init_we),
        .o_init_dir (w_init_dir),
        .o_init_dato(w_init_dato)
    );

    assign w_esc = w_oper && we && ({1'b0, dir_esc} < LIM);

    always_ff @(posedge clk) begin
        if (w_init_we)
            r_mem[w_init_dir] <= w_init_dato;
        else if (w_esc)
            r_mem[dir_esc] <= dato;
    end

    for (genvar k = 0; k < N_LECT; k++) begin : g_lect
        logic [DIR_W-1:0] w_dir;
        logic             w_valido;
        logic             w_byp;
        logic [ANCHO-1:0] r_q;
        assign w_dir    = dir_lect[k*DIR_W +: DIR_W];
        assign w_valido = {1'b0, w_dir} < LIM;
`ifdef BANCO_BYPASS_EN
        assign w_byp = w_esc && (w_dir == dir_esc);
`else
        assign w_byp = 1'b0;
`endif
        // Output is forced to zero while initialising so stale contents never leak out.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_q <= '0;
            else if (!w_oper)
                r_q <= '0;
            else
                r_q <= !w_valido ? '0 : w_byp ? dato : r_mem[w_dir];
        end
        assign q[k*ANCHO +: ANCHO] = r_q;
    end

endmodule

// File: doc/banco_reg_multipuerto.md
Name: banco_reg_multipuerto

Overview:
Parametrised synchronous register file that generalises the fixed 32x32 single-port memory to configurable width, depth and number of read ports. It has a hardware initialisation sequencer that loads the power-on contents (entry i = i+1 for the low entries, 0 elsewhere) one entry per cycle. The sequencer runs after reset and on a software clear request. It sits between the datapath write-back stage and the operand-fetch read ports.

Parameters:
ANCHO, 32, data word width in bits
PROF, 32, number of entries (>=2, need not be a power of two)
N_LECT, 2, number of independent read ports (>=1)
N_INIT, 8, entries below this index initialise to index+1; entries at or above it initialise to 0 (N_INIT <= PROF)
DIR_W (localparam), $clog2(PROF), address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
limpiar  in  1  single-cycle pulse; restarts the initialisation sequence
we  in  1  write enable
dir_esc  in  DIR_W  write address
dato  in  ANCHO  write data
dir_lect  in  N_LECT*DIR_W  packed read addresses; port k uses bits [k*DIR_W +: DIR_W]
q  out  N_LECT*ANCHO  packed registered read data; port k uses [k*ANCHO +: ANCHO]
ocupado  out  1  high while the initialisation sequencer is active
rechazo  out  1  one-cycle pulse: a write was dropped because ocupado was high

Behaviour:
- Reset (rst_n low, asynchronous assert): q = 0, ocupado = 1, rechazo = 0, state = INIT, init counter = 0. The array itself has no reset.
- Reset release is synchronous: the first rising edge with rst_n high begins counting.
- FSM states: INIT and OPER.
- INIT:
  - Each cycle writes init value (cnt < N_INIT ? cnt+1 : 0), zero-extended to ANCHO, into entry cnt, then increments cnt.
  - After writing entry PROF-1, the next state is OPER and ocupado falls. Total: PROF cycles with ocupado high after reset release.
- OPER to INIT: when limpiar is seen high in OPER, cnt clears to 0 and ocupado rises on the next cycle. limpiar during INIT is ignored; the sequence is not restarted.
- Writes:
  - In OPER with we=1 and dir_esc < PROF, mem[dir_esc] <= dato at the rising edge.
  - A write with dir_esc >= PROF is silently ignored.
  - we=1 while ocupado=1: write dropped, rechazo=1 on the next cycle.
  - A write in the same cycle limpiar is sampled is performed; INIT then overwrites it.
- Reads:
  - Latency 1. q port k <= mem[dir_lect k] on every rising edge in OPER.
  - dir_lect k >= PROF gives q = 0.
  - During INIT, q is held at 0.
- Multiple ports may read the same address in the same cycle with no restriction.
- Same-cycle write/read of the same address: result depends on BYPASS_EN (see below).
- Reset asserted mid-INIT or mid-OPER restarts INIT from entry 0 after release.

Optional Feature:
BANCO_BYPASS_EN
- Defined: in OPER, if we=1, dir_esc < PROF and dir_lect k == dir_esc, q port k takes dato, i.e. the newly written value (write-through).
- Undefined: q port k takes the pre-write array contents (read-before-write). The array update is identical in both builds.

Decomposition:
- Package banco_pkg: state enum estado_t {INIT, OPER}, and function val_init(idx, n_init) returning idx+1 or 0.
- Sub-module banco_seq_init holds the FSM, cnt, ocupado and rechazo generation. It outputs the init write address, data and enable to the storage/read logic in the top.
- Read ports come from a generate loop over N_LECT; no separate module.

Test Plan:
- Reset, release, wait PROF cycles with default params -> ocupado high for exactly 32 cycles; then reading addresses 0..7 gives 1..8 and 8..31 gives 0 after 1 cycle.
- In OPER, write 0xDEADBEEF to address 5, then read it on both ports one cycle later -> q0 = q1 = 0xDEADBEEF.
- Same-cycle write 0x1234 to address 3 with dir_lect0 = 3 -> q0 = 0x1234 with BANCO_BYPASS_EN, q0 = 4 without it.
- Pulse limpiar after writing address 2 = 0xFF -> ocupado high for 32 cycles; a write attempted mid-sequence gives a rechazo pulse; afterwards address 2 reads 3.
- PROF=20 instance: write to address 25 and read address 25 -> no array change, q = 0.
- Assert rst_n low at cycle 10 of INIT -> q = 0 and ocupado = 1 immediately; after release a full PROF-cycle INIT runs and contents are correct.
